mat_mul_ctrl: RTL and testbench

MAT_MUL_CTRL -- requirements
Module: mat_mul_ctrl

---
 rtl/mat_mul_pkg.sv | 25 ++
 rtl/mm_operand_bank.sv | 31 +++
 rtl/mat_mul_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mat_mul_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mul_pkg.sv
// Shared types and constants for the matrix-multiply controller.
//   N    : rows of A / columns of B
//   K    : dot-product length (bytes per operand row)
//   OPW  : operand element width
//   RESW : signed result width
package mat_mul_pkg;

    localparam int unsigned N    = 4;
    localparam int unsigned K    = 16;
    localparam int unsigned OPW  = 8;
    localparam int unsigned RESW = 20;
    localparam int unsigned ROWW = K * OPW;
    localparam int unsigned IDXW = $clog2(N);

    // One operand row: byte n is element n.
    typedef logic [ROWW-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/mm_operand_bank.sv
// N-entry operand register file: one synchronous write port, one
// combinational read port.
//   clk     : clock
//   we      : write enable
//   waddr   : write entry
//   wdata   : write row
//   raddr   : read entry
//   rdata_c : read row (combinational)
module mm_operand_bank
    import mat_mul_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [IDXW-1:0] waddr,
    input  row_t            wdata,
    input  logic [IDXW-1:0] raddr,
    output row_t            rdata_c
);

    row_t mem [N];

    // Storage is intentionally not reset; only control state is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/mat_mul_ctrl.sv
// Matrix-multiply controller: loads A rows / B columns, streams the N*N
// operand pairs to an external 2-cycle mac, collects the results and
// hands them out over a valid/ready port.
//   clk, reset                 : clock, async active-high reset
//   ld_valid/ld_ready/ld_sel/
//   ld_row/ld_data             : operand load port (sel 0 = A, 1 = B)
//   start, busy, done          : control
//   mac_x, mac_y               : operand pairs to the mac
//   mac_reset_mul/add, mac_out : mac clears and result
//   res_valid/res_ready/
//   res_data/res_idx           : result port, idx = i*N+j
module mat_mul_ctrl
    import mat_mul_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned K = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic                       ld_sel,
    input  logic [$clog2(N)-1:0]       ld_row,
    input  logic [K*OPW-1:0]           ld_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [K*OPW-1:0]           mac_x,
    output logic [K*OPW-1:0]           mac_y,
    output logic                       mac_reset_mul,
    output logic                       mac_reset_add,
    input  logic [RESW-1:0]            mac_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RESW-1:0]            res_data,
    output logic [$clog2(N*N)-1:0]     res_idx
);

    localparam int unsigned NR = N * N;
    localparam int unsigned KW = $clog2(NR);
    localparam int unsigned AW = $clog2(N);

    state_t          state, state_nxt;
    logic [KW-1:0]   issue_k;
    logic [KW-1:0]   out_idx;
    logic            drain_cnt;
    logic            tag0_v, tag1_v;
    logic [KW-1:0]   tag0_k, tag1_k;
    logic [RESW-1:0] res_buf [NR];
    row_t            a_row, b_row;
    logic            ld_fire;

    assign ld_fire = ld_valid & ld_ready;

    // Operand banks; read addresses follow the issue index i = k/N, j = k%N.
    mm_operand_bank u_bank_a (
        .clk     (clk),
        .we      (ld_fire & ~ld_sel),
        .waddr   (ld_row),
        .wdata   (ld_data),
        .raddr   (AW'(issue_k >> AW)),
        .rdata_c (a_row)
    );

    mm_operand_bank u_bank_b (
        .clk     (clk),
        .we      (ld_fire & ld_sel),
        .waddr   (ld_row),
        .wdata   (ld_data),
        .raddr   (AW'(issue_k)),
        .rdata_c (b_row)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control outputs.
    always_comb begin
        state_nxt     = state;
        ld_ready      = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        mac_x         = '0;
        mac_y         = '0;
        mac_reset_mul = 1'b0;
        mac_reset_add = 1'b0;
        res_valid     = 1'b0;
        case (state)
            IDLE: begin
                ld_ready      = 1'b1;
                busy          = 1'b0;
                mac_reset_mul = 1'b1;
                mac_reset_add = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mac_x = a_row;
                mac_y = b_row;
                if (issue_k == KW'(NR - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Two cycles let the last issue reach the result buffer.
                if (drain_cnt) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                mac_reset_mul = 1'b1;
                mac_reset_add = 1'b1;
                res_valid     = 1'b1;
                if (res_ready && (out_idx == KW'(NR - 1))) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters and the (valid, k) tag pipeline matching mac latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_k   <= '0;
            out_idx   <= '0;
            drain_cnt <= 1'b0;
            tag0_v    <= 1'b0;
            tag0_k    <= '0;
            tag1_v    <= 1'b0;
            tag1_k    <= '0;
        end else begin
            issue_k   <= (state == RUN) ? issue_k + 1'b1 : '0;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (state == OUT) begin
                if (res_ready) begin
                    out_idx <= out_idx + 1'b1;
                end
            end else begin
                out_idx <= '0;
            end
            tag0_v <= (state == RUN);
            tag0_k <= issue_k;
            tag1_v <= tag0_v;
            tag1_k <= tag0_k;
        end
    end

    // Result capture: mac_out belongs to the issue tagged two cycles ago.
    always_ff @(posedge clk) begin
        if (tag1_v) begin
            res_buf[tag1_k] <= mac_out;
        end
    end

    assign res_idx  = out_idx;
    assign res_data = res_buf[out_idx];

endmodule

// File: tb/tb_mat_mul_ctrl.sv
module tb_mat_mul_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         ld_valid;
    logic         ld_ready;
    logic         ld_sel;
    logic [1:0]   ld_row;
    logic [127:0] ld_data;
    logic         start;
    logic         busy;
    logic         done;
    logic [127:0] mac_x;
    logic [127:0] mac_y;
    logic         mac_reset_mul;
    logic         mac_reset_add;
    logic [19:0]  mac_out;
    logic         res_valid;
    logic         res_ready;
    logic [19:0]  res_data;
    logic [3:0]   res_idx;

    int errors = 0;
    int checks = 0;
    int cyc;

    logic [127:0]       a_ref [4];
    logic [127:0]       b_ref [4];
    logic signed [19:0] got_data [32];
    logic [3:0]         got_idx [32];
    int                 n_got;
    int                 done_cyc;
    int                 done_count;
    int                 unstable;
    bit                 timed_out;
    bit                 hold_start;

    always #5 clk = ~clk;

    mat_mul_ctrl #(.N(4), .K(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_sel        (ld_sel),
        .ld_row        (ld_row),
        .ld_data       (ld_data),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mac_x         (mac_x),
        .mac_y         (mac_y),
        .mac_reset_mul (mac_reset_mul),
        .mac_reset_add (mac_reset_add),
        .mac_out       (mac_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_idx       (res_idx)
    );

    // Reference mac: product stage then sum stage, latency 2.
    logic signed [15:0] prod [16];
    logic signed [19:0] msum;
    assign mac_out = msum;

    always @(posedge clk) begin : mac_model
        logic signed [19:0] acc;
        acc = '0;
        for (int n = 0; n < 16; n++) acc += prod[n];
        msum <= mac_reset_add ? 20'sd0 : acc;
        for (int n = 0; n < 16; n++)
            prod[n] <= mac_reset_mul ? 16'sd0 :
                       $signed(mac_x[8*n +: 8]) * $signed(mac_y[8*n +: 8]);
    end

    function automatic logic signed [19:0] dot(input logic [127:0] a, input logic [127:0] b);
        logic signed [19:0] s;
        s = '0;
        for (int n = 0; n < 16; n++) s += $signed(a[8*n +: 8]) * $signed(b[8*n +: 8]);
        return s;
    endfunction

    task automatic load_beat(input bit sel, input int row, input logic [127:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_row   = 2'(row);
        ld_data  = data;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < 4; r++) load_beat(1'b0, r, a_ref[r]);
        for (int r = 0; r < 4; r++) load_beat(1'b1, r, b_ref[r]);
    endtask

    task automatic do_start(input bit with_load, input bit sel, input int row,
                            input logic [127:0] data);
        start = 1'b1;
        if (with_load) begin
            ld_valid = 1'b1;
            ld_sel   = sel;
            ld_row   = 2'(row);
            ld_data  = data;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        ld_valid = 1'b0;
        cyc      = 1;
    endtask

    // Drains the result port; records handshakes, done timing and stability.
    task automatic collect(input bit stall);
        bit          prev_stall;
        logic [19:0] pd;
        logic [3:0]  pi;
        n_got      = 0;
        timed_out  = 1'b1;
        done_cyc   = 0;
        done_count = 0;
        unstable   = 0;
        prev_stall = 1'b0;
        pd         = '0;
        pi         = '0;
        repeat (400) begin
            res_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = hold_start;
            #1;
            if (prev_stall && res_valid && (res_data !== pd || res_idx !== pi)) unstable++;
            prev_stall = res_valid && !res_ready;
            pd = res_data;
            pi = res_idx;
            if (done) done_count++;
            if (res_valid && res_ready) begin
                if (n_got < 32) begin
                    got_data[n_got] = res_data;
                    got_idx[n_got]  = res_idx;
                end
                n_got++;
                if (done) begin
                    done_cyc  = cyc;
                    timed_out = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (!timed_out) break;
        end
        res_ready = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (mac_x !== 128'd0 || mac_y !== 128'd0) begin errors++; $display("FAIL reset_mac_xy: got %h/%h want 0", mac_x, mac_y); end
        checks++; if (mac_reset_mul !== 1'b1 || mac_reset_add !== 1'b1) begin errors++; $display("FAIL reset_mac_reset: got %b%b want 11", mac_reset_mul, mac_reset_add); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    endtask

    task automatic test_identity();
        for (int i = 0; i < 4; i++) a_ref[i] = 128'(1) << (8 * i);
        for (int j = 0; j < 4; j++) b_ref[j] = {16{8'(j + 1)}};
        load_all();
        do_start(1'b0, 1'b0, 0, '0);
        collect(1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL ident_timeout: got no done want done"); end
        checks++; if (n_got !== 16) begin errors++; $display("FAIL ident_count: got %0d want 16", n_got); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_idx[k] !== 4'(k) || got_data[k] !== 20'(k % 4 + 1)) begin
                errors++;
                $display("FAIL ident_res[%0d]: got idx %0d data %0d want idx %0d data %0d",
                         k, got_idx[k], got_data[k], k, k % 4 + 1);
            end
        end
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL ident_done_cycle: got %0d want 34", done_cyc); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL ident_done_pulses: got %0d want 1", done_count); end
        checks++; if (busy !== 1'b0 || ld_ready !== 1'b1) begin errors++; $display("FAIL ident_idle_after: got busy %b ld_ready %b want 0 1", busy, ld_ready); end
    endtask

    task automatic test_extremes();
        for (int r = 0; r < 4; r++) begin
            a_ref[r] = {16{8'h80}};
            b_ref[r] = {16{8'h80}};
        end
        load_all();
        do_start(1'b0, 1'b0, 0, '0);
        collect(1'b0);
        checks++; if (timed_out || n_got !== 16) begin errors++; $display("FAIL ext_count: got %0d results want 16", n_got); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_data[k] !== 20'sd262144) begin
                errors++;
                $display("FAIL ext_res[%0d]: got %0d want 262144", k, got_data[k]);
            end
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 4; i++)
            for (int n = 0; n < 16; n++) a_ref[i][8*n +: 8] = 8'(i * 16 + n - 64);
        for (int j = 0; j < 4; j++)
            for (int n = 0; n < 16; n++) b_ref[j][8*n +: 8] = 8'((j * 3 + n * 5) % 50 - 20);
        load_all();
        do_start(1'b0, 1'b0, 0, '0);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (mac_x !== a_ref[k / 4] || mac_y !== b_ref[k % 4] || mac_reset_mul !== 1'b0) begin
                errors++;
                $display("FAIL lat_issue[%0d]: got x %h y %h rm %b want x %h y %h rm 0",
                         k, mac_x, mac_y, mac_reset_mul, a_ref[k / 4], b_ref[k % 4]);
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (mac_x !== 128'd0 || mac_reset_add !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lat_drain: got x %h ra %b busy %b want 0 0 1", mac_x, mac_reset_add, busy);
        end
        collect(1'b0);
        checks++; if (timed_out || n_got !== 16) begin errors++; $display("FAIL lat_count: got %0d results want 16", n_got); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_data[k] !== dot(a_ref[k / 4], b_ref[k % 4])) begin
                errors++;
                $display("FAIL lat_res[%0d]: got %0d want %0d", k, got_data[k], dot(a_ref[k / 4], b_ref[k % 4]));
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) a_ref[i] = 128'(1) << (8 * i);
        for (int j = 0; j < 4; j++) b_ref[j] = {16{8'(10 * j - 7)}};
        load_all();
        do_start(1'b0, 1'b0, 0, '0);
        collect(1'b1);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
        checks++; if (n_got !== 16) begin errors++; $display("FAIL bp_count: got %0d want 16", n_got); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes during stall want 0", unstable); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_idx[k] !== 4'(k) || got_data[k] !== 20'(10 * (k % 4) - 7)) begin
                errors++;
                $display("FAIL bp_res[%0d]: got idx %0d data %0d want idx %0d data %0d",
                         k, got_idx[k], got_data[k], k, 10 * (k % 4) - 7);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 4; i++) a_ref[i] = 128'(1) << (8 * i);
        for (int j = 0; j < 4; j++) b_ref[j] = {16{8'(j + 1)}};
        load_all();
        do_start(1'b0, 1'b0, 0, '0);
        repeat (7) @(posedge clk);
        #1;
        checks++; if (mac_x !== a_ref[1] || mac_y !== b_ref[3]) begin errors++; $display("FAIL rst_k7_issue: got x %h y %h want row1/col3", mac_x, mac_y); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (mac_reset_mul !== 1'b1 || mac_reset_add !== 1'b1) begin errors++; $display("FAIL rst_mid_mac_reset: got %b%b want 11", mac_reset_mul, mac_reset_add); end
        checks++; if (mac_x !== 128'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got x %h rv %b want 0 0", mac_x, res_valid); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ld_ready: got %b want 1", ld_ready); end
        for (int j = 0; j < 4; j++) b_ref[j] = {16{8'(2 * j - 3)}};
        load_all();
        do_start(1'b0, 1'b0, 0, '0);
        collect(1'b0);
        checks++; if (timed_out || n_got !== 16) begin errors++; $display("FAIL rst_rerun_count: got %0d results want 16", n_got); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got_idx[k] !== 4'(k) || got_data[k] !== 20'(2 * (k % 4) - 3)) begin
                errors++;
                $display("FAIL rst_rerun_res[%0d]: got idx %0d data %0d want idx %0d data %0d",
                         k, got_idx[k], got_data[k], k, 2 * (k % 4) - 3);
            end
        end
    endtask

    task automatic test_concurrency();
        int expv;
        for (int i = 0; i < 4; i++) a_ref[i] = 128'(1) << (8 * i);
        for (int j = 0; j < 4; j++) b_ref[j] = {16{8'(j + 1)}};
        load_all();
        // B column 0 rewritten in the start cycle; the run must see 5s.
        do_start(1'b1, 1'b1, 0, {16{8'd5}});
        checks++; if (ld_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL conc_ld_ready_busy: got ld_ready %b busy %b want 0 1", ld_ready, busy); end
        // Offered load while busy must be dropped.
        ld_valid = 1'b1;
        ld_sel   = 1'b1;
        ld_row   = 2'd1;
        ld_data  = {16{8'h7f}};
        @(posedge clk); #1;
        ld_valid = 1'b0;
        cyc++;
        hold_start = 1'b1;
        collect(1'b0);
        hold_start = 1'b0;
        checks++; if (timed_out || n_got !== 16 || done_count !== 1) begin errors++; $display("FAIL conc_count: got %0d results %0d done want 16 1", n_got, done_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conc_start_in_out: got busy %b want 0", busy); end
        for (int k = 0; k < 16; k++) begin
            expv = (k % 4 == 0) ? 5 : (k % 4 + 1);
            checks++;
            if (got_idx[k] !== 4'(k) || got_data[k] !== 20'(expv)) begin
                errors++;
                $display("FAIL conc_res[%0d]: got idx %0d data %0d want idx %0d data %0d",
                         k, got_idx[k], got_data[k], k, expv);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        ld_valid   = 1'b0;
        ld_sel     = 1'b0;
        ld_row     = '0;
        ld_data    = '0;
        start      = 1'b0;
        res_ready  = 1'b0;
        hold_start = 1'b0;
        cyc        = 0;
        test_reset();
        test_identity();
        test_extremes();
        test_latency();
        test_backpressure();
        test_reset_mid_run();
        test_concurrency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
